pc_seq_ctrl: RTL and testbench

- Upstream next-PC sequencer for the 4-bit program counter register.
- Runs a fetch/decode/execute FSM, computes the next PC (increment, jump, conditional jump, halt) and drives the PC register's load strobe and data input.
- Registers on posedge clk, so its outputs are stable when the PC register samples on negedge clk.
- Reads the current PC back from the PC register output.

---
 rtl/pc_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer for a 4-bit program counter register.
// Steps through FETCH -> DECODE -> EXEC and hands the PC register a one-cycle
// load strobe plus the next PC value. All outputs are registered on the rising
// edge, so they are stable when the PC register samples on the falling edge.
// Optional feature: define PC_SEQ_SKIP_EN to enable opcode 0xE as SKZ
// (skip next instruction when zero=1). Without it, 0xE is a NOP.
module pc_seq_ctrl #(
  parameter int                ADDR_W    = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W+3:0] instr_in,
  input  logic              zero,
  input  logic [ADDR_W-1:0] PC_out,
  output logic              PCload,
  output logic [ADDR_W-1:0] PC_in,
  output logic              ir_load,
  output logic              halted,
  output logic              wrap,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_SKZ = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W+3:0]   ir;
  logic [ADDR_W-1:0]   pc_next;
  logic                wrap_next;

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [ADDR_W:0]     inc1;
  logic [ADDR_W:0]     inc2;

  assign opcode  = ir[ADDR_W+3:ADDR_W];
  assign operand = ir[ADDR_W-1:0];
  // The extra top bit of each sum is the carry out of the max PC.
  assign inc1    = {1'b0, PC_out} + (ADDR_W+1)'(1);
  assign inc2    = {1'b0, PC_out} + (ADDR_W+1)'(2);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-PC decode; the DECODE cycle resolves the branch.
  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = PC_in;
    wrap_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) state_next = FETCH;
      end
      FETCH: begin
        state_next = DECODE;
      end
      DECODE: begin
        if (opcode == OP_HLT) begin
          state_next = HALT;
        end else begin
          state_next = EXEC;
          pc_next    = inc1[ADDR_W-1:0];
          wrap_next  = inc1[ADDR_W];
          case (opcode)
            OP_JMP: begin
              pc_next   = operand;
              wrap_next = 1'b0;
            end
            OP_JZ: begin
              if (zero) begin
                pc_next   = operand;
                wrap_next = 1'b0;
              end
            end
`ifdef PC_SEQ_SKIP_EN
            OP_SKZ: begin
              if (zero) begin
                pc_next   = inc2[ADDR_W-1:0];
                wrap_next = inc2[ADDR_W];
              end
            end
`endif
            default: ;
          endcase
        end
      end
      EXEC: begin
        state_next = stop ? IDLE : FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs: registered from the state being entered, so each strobe
  // is high for exactly the cycle spent in its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCload  <= 1'b0;
      ir_load <= 1'b0;
      halted  <= 1'b0;
      wrap    <= 1'b0;
      PC_in   <= RESET_VEC;
      retired <= '0;
    end else begin
      PCload  <= (state_next == EXEC);
      ir_load <= (state_next == FETCH);
      halted  <= (state_next == HALT);
      wrap    <= (state_next == EXEC) && wrap_next;
      if (state_next == EXEC) begin
        PC_in <= pc_next;
        if (retired != '1) retired <= retired + CNT_W'(1);
      end
    end
  end

  // Instruction register: captures the word presented during FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir <= '0;
    end else if (state == FETCH) begin
      ir <= instr_in;
    end
  end

  // OP_SKZ is only decoded when the skip feature is built in.
  logic unused_ok;
  assign unused_ok = ^{OP_SKZ, inc2};

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed self-checking bench for pc_seq_ctrl. The bench plays the PC
// register and the ALU by driving PC_out and zero directly.
module tb_pc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] instr_in;
  logic       zero;
  logic [3:0] PC_out;
  logic       PCload;
  logic [3:0] PC_in;
  logic       ir_load;
  logic       halted;
  logic       wrap;
  logic [7:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ret  = 0;

  pc_seq_ctrl #(.ADDR_W(4), .RESET_VEC(4'h0), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .instr_in (instr_in),
    .zero     (zero),
    .PC_out   (PC_out),
    .PCload   (PCload),
    .PC_in    (PC_in),
    .ir_load  (ir_load),
    .halted   (halted),
    .wrap     (wrap),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one instruction from FETCH through EXEC and checks the EXEC outputs.
  task automatic do_instr(input string tag, input logic [3:0] pc, input logic [7:0] instr,
                          input logic z, input logic [3:0] exp_pc, input logic exp_wrap,
                          input logic stop_in_decode);
    bit seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ir_load) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_fetch"}, 32'(seen), 32'd1);
    if (!seen) return;
    instr_in = instr;
    PC_out   = pc;
    zero     = z;
    @(posedge clk); #1;
    check({tag, "_dec_pcload"}, 32'(PCload), 32'd0);
    if (stop_in_decode) stop = 1'b1;
    @(posedge clk); #1;
    if (exp_ret < 255) exp_ret++;
    check({tag, "_pcload"}, 32'(PCload), 32'd1);
    check({tag, "_pc_in"}, 32'(PC_in), 32'(exp_pc));
    check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
    check({tag, "_retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    instr_in = 8'h00; zero = 1'b0; PC_out = 4'h0;

    // Reset values
    #12;
    check("rst_pcload", 32'(PCload), 32'd0);
    check("rst_pc_in", 32'(PC_in), 32'd0);
    check("rst_ir_load", 32'(ir_load), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);

    // Stop has priority over start in IDLE
    @(negedge clk); reset = 1'b1; start = 1'b1; stop = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("idle_stop_prio", 32'(ir_load), 32'd0);
    stop = 1'b0;

    // Back-to-back NOPs: one EXEC every 3 cycles, PC_in held outside EXEC
    for (int k = 0; k < 4; k++) begin
      do_instr($sformatf("nop%0d", k), 4'(3 + k), 8'h05, 1'b0, 4'(4 + k), 1'b0, 1'b0);
      @(posedge clk); #1;
      check($sformatf("gap%0d", k), 32'(ir_load), 32'd1);
      check($sformatf("hold%0d", k), 32'(PC_in), 32'(4 + k));
      check($sformatf("pulse%0d", k), 32'(PCload), 32'd0);
    end

    // Jumps and increment wrap
    do_instr("jmp9", 4'h2, 8'hC9, 1'b0, 4'h9, 1'b0, 1'b0);
    do_instr("inc_wrap", 4'hF, 8'h01, 1'b0, 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("wrap_one_cycle", 32'(wrap), 32'd0);
    do_instr("jmp0_from_f", 4'hF, 8'hC0, 1'b0, 4'h0, 1'b0, 1'b0);

    // Conditional jump
    do_instr("jz_taken", 4'h3, 8'hD6, 1'b1, 4'h6, 1'b0, 1'b0);
    do_instr("jz_not", 4'h3, 8'hD6, 1'b0, 4'h4, 1'b0, 1'b0);

    // SKZ (or NOP when the skip feature is absent)
    do_instr("skz_nz_f", 4'hF, 8'hE0, 1'b0, 4'h0, 1'b1, 1'b0);
`ifdef PC_SEQ_SKIP_EN
    do_instr("skz_d", 4'hD, 8'hE0, 1'b1, 4'hF, 1'b0, 1'b0);
    do_instr("skz_e", 4'hE, 8'hE0, 1'b1, 4'h0, 1'b1, 1'b1);
`else
    do_instr("skz_d", 4'hD, 8'hE0, 1'b1, 4'hE, 1'b0, 1'b0);
    do_instr("skz_e", 4'hE, 8'hE0, 1'b1, 4'hF, 1'b0, 1'b1);
`endif
    // stop raised in DECODE: the instruction completed above, now IDLE
    @(posedge clk); #1;
    check("stop_idle_ir_load", 32'(ir_load), 32'd0);
    check("stop_idle_pcload", 32'(PCload), 32'd0);
    repeat (2) @(posedge clk); #1;
    check("stop_idle_stays", 32'(ir_load), 32'd0);
    stop = 1'b0;

    // Reset mid-EXEC cuts the strobe and clears the count
    do_instr("pre_rst", 4'h8, 8'h00, 1'b0, 4'h9, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    exp_ret = 0;
    check("midrst_pcload", 32'(PCload), 32'd0);
    check("midrst_pc_in", 32'(PC_in), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_ir_load", 32'(ir_load), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_fetch", 32'(ir_load), 32'd1);

    // HALT: no load, no retire, start/stop ignored until reset
    do_instr("pre_hlt", 4'h0, 8'h00, 1'b0, 4'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    instr_in = 8'hF0; PC_out = 4'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_pcload", 32'(PCload), 32'd0);
    check("hlt_retired", 32'(retired), 32'(exp_ret));
    begin
      bit bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
        start = i[0];
        stop  = i[1];
        @(posedge clk); #1;
        if (PCload || ir_load || !halted) bad = 1'b1;
      end
      check("hlt_sticky", 32'(bad), 32'd0);
    end
    reset = 1'b0; #1;
    check("hlt_reset", 32'(halted), 32'd0);

    // Retired counter saturates
    stop = 1'b0; start = 1'b1; instr_in = 8'h00; PC_out = 4'h0; zero = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (800) @(posedge clk); #1;
    check("sat_retired", 32'(retired), 32'd255);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (PCload) begin
          seen = 1'b1;
          break;
        end
      end
      check("sat_exec_seen", 32'(seen), 32'd1);
      check("sat_hold", 32'(retired), 32'd255);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
